// File: rtl/uart_frame_decoder.sv
// Drains a FWFT UART rx FIFO, hunts for a sync byte, collects a fixed-length
// payload and verifies an 8-bit additive checksum before publishing the frame.
module uart_frame_decoder #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_CYC   = 65535,
  parameter int unsigned TO_BITS       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_empty,
  input  logic [7:0]                   rx_data,
  output logic                         rd_uart,
  output logic [8*PAYLOAD_BYTES-1:0]   payload,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic [7:0]                   err_cnt,
  output logic                         busy
);

  localparam int unsigned IDX_BITS = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t                       state, state_next;
  logic [IDX_BITS-1:0]          idx, idx_next;
  logic [7:0]                   sum, sum_next;
  logic [TO_BITS-1:0]           timer, timer_next;
  logic [8*PAYLOAD_BYTES-1:0]   shadow;
  logic                         store_en, load_en, valid_next, err_next;
  logic                         accept, timeout_hit;

  assign rd_uart     = ~rx_empty;
  assign accept      = rd_uart;
  assign busy        = (state != HUNT);
  // Timer counts idle cycles; the idle cycle that would bring it to TIMEOUT_CYC aborts.
  assign timeout_hit = (timer == TO_BITS'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next = state;
    idx_next   = idx;
    sum_next   = sum;
    timer_next = '0;
    store_en   = 1'b0;
    load_en    = 1'b0;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      HUNT: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_next = PAYLOAD;
          idx_next   = '0;
          sum_next   = '0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          store_en = 1'b1;
          sum_next = sum + rx_data;
          if (idx == IDX_BITS'(PAYLOAD_BYTES - 1)) state_next = CHECK;
          else                                     idx_next   = idx + 1'b1;
        end else if (timeout_hit) begin
          state_next = HUNT;
          err_next   = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      CHECK: begin
        if (accept) begin
          state_next = HUNT;
          if (rx_data == sum) begin
            valid_next = 1'b1;
            load_en    = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next = HUNT;
          err_next   = 1'b1;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HUNT;
      idx   <= '0;
      sum   <= '0;
      timer <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      sum   <= sum_next;
      timer <= timer_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow      <= '0;
      payload     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      if (store_en) shadow[8*idx +: 8] <= rx_data;
      if (load_en)  payload <= shadow;
      frame_valid <= valid_next;
      frame_err   <= err_next;
      if (err_next && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed scenarios plus random
// frames compared cycle by cycle against a queue-based frame model.
module tb_uart_frame_decoder;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 20;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic               clk;
  logic               reset;
  logic               rx_empty;
  logic [7:0]         rx_data;
  logic               rd_uart;
  logic [8*N-1:0]     payload;
  logic               frame_valid;
  logic               frame_err;
  logic [7:0]         err_cnt;
  logic               busy;

  uart_frame_decoder #(
    .PAYLOAD_BYTES(N),
    .SYNC_BYTE    (SYNC),
    .TIMEOUT_CYC  (TO),
    .TO_BITS      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rd_uart    (rd_uart),
    .payload    (payload),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Frame-level reference model: collects bytes after a sync into a queue.
  bit             m_in;
  logic [7:0]     m_q[$];
  int             m_idle;
  logic [8*N-1:0] m_payload;
  logic [7:0]     m_errcnt;
  bit             m_valid, m_err;
  int             m_nvalid, m_nerr;

  // Observed activity, accumulated every cycle.
  int    n_valid, n_err, n_rd, mism;
  string first_mism;

  task automatic model_reset();
    m_in = 0; m_q.delete(); m_idle = 0; m_payload = '0; m_errcnt = '0;
    m_valid = 0; m_err = 0;
  endtask

  task automatic model_step(input bit present, input logic [7:0] b);
    logic [7:0] s;
    m_valid = 0; m_err = 0;
    if (present) begin
      if (!m_in) begin
        if (b == SYNC) begin m_in = 1; m_q.delete(); end
      end else if (m_q.size() < N) begin
        m_q.push_back(b);
      end else begin
        s = 8'h00;
        foreach (m_q[i]) s = s + m_q[i];
        if (s == b) begin
          for (int i = 0; i < N; i++) m_payload[8*i +: 8] = m_q[i];
          m_valid = 1;
        end else begin
          m_err = 1;
        end
        m_in = 0;
      end
      m_idle = 0;
    end else if (m_in) begin
      m_idle++;
      if (m_idle == TO) begin m_in = 0; m_err = 1; end
    end
    if (m_err && m_errcnt != 8'd255) m_errcnt = m_errcnt + 8'd1;
    if (m_valid) m_nvalid++;
    if (m_err)   m_nerr++;
  endtask

  task automatic step(input bit present, input logic [7:0] b);
    @(negedge clk);
    rx_empty = !present;
    rx_data  = present ? b : 8'($urandom);
    #1;
    if (rd_uart !== present) begin
      mism++;
      if (first_mism == "") first_mism = $sformatf("t=%0t rd_uart=%b want %b", $time, rd_uart, present);
    end
    if (rd_uart === 1'b1) n_rd++;
    model_step(present, b);
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1)   n_err++;
    if (frame_valid !== m_valid || frame_err !== m_err || payload !== m_payload ||
        err_cnt !== m_errcnt || busy !== m_in) begin
      mism++;
      if (first_mism == "")
        first_mism = $sformatf("t=%0t v=%b/%b e=%b/%b p=%h/%h c=%0d/%0d busy=%b/%b", $time,
                               frame_valid, m_valid, frame_err, m_err, payload, m_payload,
                               err_cnt, m_errcnt, busy, m_in);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    repeat (gap) step(1'b0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] d0, d1, d2, d3, ck, input int gap);
    send(SYNC, gap); send(d0, gap); send(d1, gap); send(d2, gap); send(d3, gap); send(ck, gap);
  endtask

  task automatic clear_track();
    mism = 0; first_mism = "";
  endtask

  task automatic check_model(input string name);
    checks++;
    if (mism !== 0) begin
      failures++;
      $display("FAIL %s: cycle mismatches=%0d required 0; first: %s", name, mism, first_mism);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_empty = 1'b1; rx_data = 8'h00;
    model_reset();
    #3;
    checks++;
    if (payload !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: payload=%h valid=%b err=%b required 0/0/0", payload, frame_valid, frame_err);
    end
    checks++;
    if (err_cnt !== 8'd0 || busy !== 1'b0 || rd_uart !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: err_cnt=%0d busy=%b rd_uart=%b required 0/0/0", err_cnt, busy, rd_uart);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) step(1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    int v0, r0;
    clear_track(); v0 = n_valid; r0 = n_rd;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 0);
    checks++;
    if (frame_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_valid_latency: frame_valid=%b required 1", frame_valid);
    end
    step(1'b0, 8'h00);
    checks++;
    if (frame_valid !== 1'b0 || n_valid - v0 !== 1) begin
      failures++; $display("FAIL b2b_single_pulse: valid=%b pulses=%0d required 0/1", frame_valid, n_valid - v0);
    end
    checks++;
    if (payload !== 32'h04030201 || err_cnt !== 8'd0) begin
      failures++; $display("FAIL b2b_payload: payload=%h err_cnt=%0d required 04030201/0", payload, err_cnt);
    end
    checks++;
    if (n_rd - r0 !== 6) begin
      failures++; $display("FAIL b2b_rd_count: pops=%0d required 6", n_rd - r0);
    end
    check_model("b2b_model");
  endtask

  task automatic test_garbage_gaps();
    int v0, e0;
    clear_track(); v0 = n_valid; e0 = n_err;
    send(8'h00, 3); send(8'hFF, 3); send(8'h5A, 3);
    checks++;
    if (n_err - e0 !== 0 || busy !== 1'b0) begin
      failures++; $display("FAIL garbage_dropped: errs=%0d busy=%b required 0/0", n_err - e0, busy);
    end
    send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 3);
    checks++;
    if (payload !== 32'h40302010 || n_valid - v0 !== 1) begin
      failures++; $display("FAIL gap_frame: payload=%h pulses=%0d required 40302010/1", payload, n_valid - v0);
    end
    check_model("gap_model");
  endtask

  task automatic test_bad_checksum();
    int e0, v0;
    clear_track(); e0 = n_err; v0 = n_valid;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0B, 0);
    step(1'b0, 8'h00);
    checks++;
    if (n_err - e0 !== 1 || n_valid - v0 !== 0 || err_cnt !== 8'd1) begin
      failures++;
      $display("FAIL bad_checksum: errs=%0d valids=%0d err_cnt=%0d required 1/0/1", n_err - e0, n_valid - v0, err_cnt);
    end
    checks++;
    if (payload !== 32'h40302010 || busy !== 1'b0) begin
      failures++; $display("FAIL bad_checksum_hold: payload=%h busy=%b required 40302010/0", payload, busy);
    end
    check_model("bad_checksum_model");
  endtask

  task automatic test_timeout();
    int e0;
    clear_track();
    send(SYNC, 0); send(8'h01, 0); send(8'h02, 0);
    repeat (TO - 1) step(1'b0, 8'h00);
    checks++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL timeout_early: err=%b busy=%b required 0/1", frame_err, busy);
    end
    step(1'b0, 8'h00);
    checks++;
    if (frame_err !== 1'b1 || busy !== 1'b0 || err_cnt !== 8'd2) begin
      failures++; $display("FAIL timeout_abort: err=%b busy=%b err_cnt=%0d required 1/0/2", frame_err, busy, err_cnt);
    end
    // A byte arriving on the would-be timeout cycle keeps the frame alive.
    e0 = n_err;
    send(SYNC, 0); send(8'h01, TO - 1); send(8'h02, 0);
    checks++;
    if (busy !== 1'b1 || n_err - e0 !== 0) begin
      failures++; $display("FAIL timeout_byte_wins: busy=%b errs=%0d required 1/0", busy, n_err - e0);
    end
    send(8'h03, 0); send(8'h04, 0); send(8'h0A, 0);
    checks++;
    if (frame_valid !== 1'b1 || payload !== 32'h04030201) begin
      failures++; $display("FAIL timeout_recover: valid=%b payload=%h required 1/04030201", frame_valid, payload);
    end
    check_model("timeout_model");
  endtask

  task automatic test_sync_in_payload();
    clear_track();
    send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5, 0);
    checks++;
    if (frame_valid !== 1'b1 || payload !== 32'h000000A5) begin
      failures++; $display("FAIL sync_as_data: valid=%b payload=%h required 1/000000a5", frame_valid, payload);
    end
    check_model("sync_as_data_model");
  endtask

  task automatic test_random();
    int v0, mv0, gap, stall_at, ng;
    logic [7:0] x, s, ck;
    clear_track(); v0 = n_valid; mv0 = m_nvalid;
    for (int f = 0; f < 40; f++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        x = 8'($urandom);
        if (x == SYNC) x = 8'h00;
        send(x, $urandom_range(0, 2));
      end
      gap = $urandom_range(0, 3);
      stall_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N) : N + 1;
      send(SYNC, gap);
      s = 8'h00;
      for (int i = 0; i < N; i++) begin
        if (i == stall_at) repeat ($urandom_range(TO - 2, TO + 2)) step(1'b0, 8'h00);
        x = 8'($urandom);
        s = s + x;
        send(x, gap);
      end
      if (stall_at == N) repeat ($urandom_range(TO - 2, TO + 2)) step(1'b0, 8'h00);
      ck = ($urandom_range(0, 3) == 0) ? s + 8'($urandom_range(1, 255)) : s;
      send(ck, gap);
    end
    step(1'b0, 8'h00);
    checks++;
    if (n_valid - v0 !== m_nvalid - mv0) begin
      failures++; $display("FAIL random_valid_count: got=%0d required=%0d", n_valid - v0, m_nvalid - mv0);
    end
    check_model("random_model");
  endtask

  task automatic test_mid_frame_reset();
    clear_track();
    send(SYNC, 0); send(8'h01, 0); send(8'h02, 0);
    @(negedge clk); #2; reset = 1'b1; #1;
    checks++;
    if (payload !== '0 || err_cnt !== 8'd0 || busy !== 1'b0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: payload=%h err_cnt=%0d busy=%b v=%b e=%b required all 0",
               payload, err_cnt, busy, frame_valid, frame_err);
    end
    model_reset();
    @(negedge clk); reset = 1'b0;
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 0);
    checks++;
    if (frame_valid !== 1'b1 || payload !== 32'h44332211) begin
      failures++; $display("FAIL post_reset_frame: valid=%b payload=%h required 1/44332211", frame_valid, payload);
    end
    check_model("post_reset_model");
  endtask

  task automatic test_err_saturation();
    int e0;
    clear_track(); e0 = n_err;
    repeat (300) send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0B, 0);
    step(1'b0, 8'h00);
    checks++;
    if (err_cnt !== 8'd255 || n_err - e0 !== 300) begin
      failures++; $display("FAIL err_saturation: err_cnt=%0d errs=%0d required 255/300", err_cnt, n_err - e0);
    end
    check_model("saturation_model");
  endtask

  initial begin
    n_valid = 0; n_err = 0; n_rd = 0; m_nvalid = 0; m_nerr = 0;
    clear_track();
    test_reset();
    test_back_to_back();
    test_garbage_gaps();
    test_bad_checksum();
    test_timeout();
    test_sync_in_payload();
    test_random();
    test_mid_frame_reset();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
